// File: rtl/stack_ctrl.sv
// stack_ctrl: top-of-stack register plus controller for an external register-file store.
// Define STACK_CTRL_GUARD_EN to suppress overflowing pushes / underflowing pops and latch a sticky err.
module stack_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] n,
  output logic [DEPTH-1:0] mem_ra,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_wa,
  output logic [WIDTH-1:0] mem_wd,
  output logic [DEPTH:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};
`ifdef STACK_CTRL_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  op_e              op_s;
  logic [DEPTH-1:0] sp_r, sp_nxt_s;
  logic [WIDTH-1:0] t_r, t_nxt_s;
  logic [DEPTH:0]   count_r, count_nxt_s;
  logic             ovf_r, unf_r, err_r;
  logic             ovf_nxt_s, unf_nxt_s, we_s;
  logic             empty_s, full_s;

  assign op_s    = op_e'(op);
  assign empty_s = (count_r == {(DEPTH+1){1'b0}});
  assign full_s  = (count_r == CAP);

  // Next-state decode for T, sp, count and the error pulses
  always_comb begin
    sp_nxt_s    = sp_r;
    t_nxt_s     = t_r;
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    unf_nxt_s   = 1'b0;
    we_s        = 1'b0;
    case (op_s)
      OP_PUSH: begin
        ovf_nxt_s = full_s;
        if (GUARD && full_s) begin
          we_s = 1'b0;
        end else begin
          we_s     = 1'b1;
          t_nxt_s  = din;
          sp_nxt_s = sp_r + DEPTH'(1);
          if (full_s) begin
            count_nxt_s = count_r;
          end else begin
            count_nxt_s = count_r + (DEPTH+1)'(1);
          end
        end
      end
      OP_POP: begin
        unf_nxt_s = empty_s;
        if (GUARD && empty_s) begin
          t_nxt_s = t_r;
        end else begin
          t_nxt_s  = mem_rd;
          sp_nxt_s = sp_r - DEPTH'(1);
          if (empty_s) begin
            count_nxt_s = count_r;
          end else begin
            count_nxt_s = count_r - (DEPTH+1)'(1);
          end
        end
      end
      OP_REPL: t_nxt_s = din;
      OP_NOP:  t_nxt_s = t_r;
      default: t_nxt_s = t_r;
    endcase
  end

  // State registers; err only ever sets when the guard is built in
  always_ff @(posedge clk or posedge resetq) begin
    if (resetq) begin
      sp_r    <= {DEPTH{1'b0}};
      t_r     <= {WIDTH{1'b0}};
      count_r <= {(DEPTH+1){1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      sp_r    <= sp_nxt_s;
      t_r     <= t_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
      err_r   <= err_r | (GUARD & (ovf_nxt_s | unf_nxt_s));
    end
  end

  // A push issued while reset is held is aborted, so it must not reach the store
  assign mem_we = we_s & ~resetq;
  assign mem_ra = sp_r;
  assign mem_wa = sp_r + DEPTH'(1);
  assign mem_wd = t_r;
  assign n      = mem_rd;
  assign t      = t_r;
  assign count  = count_r;
  assign empty  = empty_s;
  assign full   = full_s;
  assign ovf    = ovf_r;
  assign unf    = unf_r;
  assign err    = err_r;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl (DEPTH=2) with a behavioural store and reference stack model.
module tb_stack_ctrl;

  localparam int W = 32;
  localparam int D = 2;
`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetq;
  logic [1:0]   op;
  logic [W-1:0] din, t, n, mem_rd, mem_wd;
  logic [D-1:0] mem_ra, mem_wa;
  logic         mem_we, empty, full, ovf, unf, err;
  logic [D:0]   count;

  logic [W-1:0] store [4];

  typedef struct {
    logic [W-1:0] t;
    logic [W-1:0] n;
    logic [D-1:0] sp;
    int           cnt;
    logic         ovf;
    logic         unf;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_mem [4];
  logic [D-1:0] m_sp;
  logic [W-1:0] m_t;
  int           m_cnt;
  logic         m_err;
  int           checks = 0;
  int           errors = 0;

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .resetq(resetq), .op(op), .din(din), .t(t), .n(n),
    .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wa(mem_wa),
    .mem_wd(mem_wd), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf), .err(err)
  );

  always #5 clk = ~clk;

  assign mem_rd = store[mem_ra];
  always @(posedge clk) if (mem_we) store[mem_wa] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive op at a negedge, check the store-side strobes, predict, then compare next negedge.
  task automatic cycle(input logic [1:0] o, input logic [W-1:0] d);
    exp_t       e;
    exp_t       g;
    logic       exp_we;
    logic       full_m, empty_m;
    logic [D-1:0] wa;
    op = o;
    din = d;
    #1;
    full_m  = (m_cnt == 4);
    empty_m = (m_cnt == 0);
    wa = m_sp + 2'd1;
    chk("mem_wa", 32'(mem_wa), 32'(wa));
    chk("mem_wd", mem_wd, m_t);
    e.ovf = 1'b0;
    e.unf = 1'b0;
    exp_we = 1'b0;
    case (o)
      2'b01: begin
        e.ovf = full_m;
        if (!(GUARD && full_m)) begin
          exp_we = 1'b1;
          m_mem[wa] = m_t;
          m_t = d;
          m_sp = wa;
          if (m_cnt < 4) m_cnt++;
        end
      end
      2'b10: begin
        e.unf = empty_m;
        if (!(GUARD && empty_m)) begin
          m_t = m_mem[m_sp];
          m_sp = m_sp - 2'd1;
          if (m_cnt > 0) m_cnt--;
        end
      end
      2'b11: m_t = d;
      default: ;
    endcase
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    if (GUARD) m_err = m_err | e.ovf | e.unf;
    e.t = m_t;
    e.n = m_mem[m_sp];
    e.sp = m_sp;
    e.cnt = m_cnt;
    e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    chk("t", t, g.t);
    chk("n", n, g.n);
    chk("mem_ra", 32'(mem_ra), 32'(g.sp));
    chk("count", 32'(count), 32'(g.cnt));
    chk("empty", 32'(empty), 32'(g.cnt == 0));
    chk("full", 32'(full), 32'(g.cnt == 4));
    chk("ovf", 32'(ovf), 32'(g.ovf));
    chk("unf", 32'(unf), 32'(g.unf));
    chk("err", 32'(err), 32'(g.err));
  endtask

  // Assert reset asynchronously in the middle of a pending push and check everything clears at once.
  task automatic async_reset();
    op = 2'b01;
    din = 32'hDEAD_BEEF;
    #2;
    resetq = 1'b1;
    #1;
    chk("rst_t", t, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_unf", 32'(unf), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ra", 32'(mem_ra), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    resetq = 1'b0;
    op = 2'b00;
    m_sp = '0;
    m_t = '0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      store[i] = '0;
      m_mem[i] = '0;
    end
    m_sp = '0;
    m_t = '0;
    m_cnt = 0;
    m_err = 1'b0;
    resetq = 1'b1;
    op = 2'b00;
    din = '0;
    repeat (2) @(negedge clk);
    chk("init_t", t, 32'h0);
    chk("init_count", 32'(count), 32'h0);
    chk("init_empty", 32'(empty), 32'h1);
    resetq = 1'b0;

    cycle(2'b01, 32'hA);
    cycle(2'b01, 32'hB);
    cycle(2'b01, 32'hC);
    chk("p3_t", t, 32'hC);
    chk("p3_n", n, 32'hB);
    chk("p3_count", 32'(count), 32'd3);
    cycle(2'b10, 32'h0);
    chk("pop1_t", t, 32'hB);
    cycle(2'b10, 32'h0);
    chk("pop2_t", t, 32'hA);
    chk("pop2_n", n, 32'h0);
    cycle(2'b01, 32'h7);
    chk("popush_ra", 32'(mem_ra), 32'd2);

    async_reset();
    cycle(2'b01, 32'h1);
    cycle(2'b11, 32'h55);
    chk("repl_t", t, 32'h55);
    chk("repl_count", 32'(count), 32'd1);

    async_reset();
    for (int i = 1; i <= 5; i++) cycle(2'b01, 32'(i));
    chk("wrap_count", 32'(count), 32'd4);
    chk("wrap_full", 32'(full), 32'h1);
    chk("wrap_sp", 32'(mem_ra), GUARD ? 32'd0 : 32'd1);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    cycle(2'b00, 32'h0);

    async_reset();
    cycle(2'b01, 32'h9);
    cycle(2'b10, 32'h0);
    cycle(2'b10, 32'h0);
    chk("unf_pulse", 32'(unf), 32'h1);
    chk("unf_err", 32'(err), 32'(GUARD));
    cycle(2'b00, 32'h0);
    cycle(2'b11, 32'h3);
    async_reset();

    for (int i = 0; i < 100; i++) cycle(2'($urandom_range(3, 0)), 32'($urandom));
    async_reset();
    cycle(2'b00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
